// File: rtl/nand_vector_checker.sv
// Stimulus-and-check stage for a 2-input NAND gate: drives the four input vectors,
// samples the gate output after a settle time and reports mismatches.
module nand_vector_checker #(
  parameter int HOLD_CYCLES = 10,
  parameter int ERR_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic             y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [1:0]       fail_vec
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] RELOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             a_q, a_d;
  logic             b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fvalid_q, fvalid_d;
  logic [1:0]       fvec_q, fvec_d;
  logic             expY;
  logic             mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      vec_q    <= '0;
      cnt_q    <= '0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fvalid_q <= 1'b0;
      fvec_q   <= '0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fvalid_q <= fvalid_d;
      fvec_q   <= fvec_d;
    end
  end

  // Case-inequality so an X or Z from the gate is counted as a failure.
  always_comb begin
    expY     = ~(a_q & b_q);
    mismatch = (y !== expY);
  end

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    fvalid_d = fvalid_q;
    fvec_d   = fvec_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = DRIVE;
          vec_d    = 2'd0;
          cnt_d    = RELOAD;
          a_d      = 1'b0;
          b_d      = 1'b0;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          err_d    = '0;
          fvalid_d = 1'b0;
          fvec_d   = 2'd0;
        end
      end
      DRIVE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          if (mismatch) begin
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_W'(1);
            end
            if (!fvalid_q) begin
              fvalid_d = 1'b1;
              fvec_d   = {a_q, b_q};
            end
          end
          if (vec_q != 2'd3) begin
            vec_d      = vec_q + 2'd1;
            {a_d, b_d} = vec_q + 2'd1;
            cnt_d      = RELOAD;
          end else begin
            // pass must see this final sample, so it is taken from err_d.
            state_d = DONE;
            a_d     = 1'b0;
            b_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign a          = a_q;
  assign b          = b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign fail_valid = fvalid_q;
  assign fail_vec   = fvec_q;

endmodule

// File: tb/tb_nand_vector_checker.sv
// Self-checking bench for nand_vector_checker: three instances with different
// hold times and counter widths, each driving a bench-modelled gate truth table.
module tb_nand_vector_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic start0, start1, start2;
  logic [3:0] tt0, tt1, tt2;

  logic a0, b0, y0, busy0, done0, pass0, fvalid0;
  logic a1, b1, y1, busy1, done1, pass1, fvalid1;
  logic a2, b2, y2, busy2, done2, pass2, fvalid2;
  logic [3:0] err0, err1;
  logic [1:0] err2;
  logic [1:0] fvec0, fvec1, fvec2;

  int checks = 0;
  int passes = 0;

  localparam logic [3:0] TT_NAND  = 4'b0111;
  localparam logic [3:0] TT_AND   = 4'b1000;
  localparam logic [3:0] TT_STUCK = 4'b1111;

  // Gate under test: output is the truth-table bit selected by {a,b}.
  assign y0 = tt0[{a0, b0}];
  assign y1 = tt1[{a1, b1}];
  assign y2 = tt2[{a2, b2}];

  nand_vector_checker #(.HOLD_CYCLES(10), .ERR_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .a(a0), .b(b0), .y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_valid(fvalid0), .fail_vec(fvec0)
  );

  nand_vector_checker #(.HOLD_CYCLES(1), .ERR_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fvalid1), .fail_vec(fvec1)
  );

  nand_vector_checker #(.HOLD_CYCLES(3), .ERR_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
    .fail_valid(fvalid2), .fail_vec(fvec2)
  );

  // Observed outputs packed as {a,b,busy,done,pass,fail_valid,fail_vec,err_count[3:0]}.
  function automatic logic [11:0] getObs(input int idx);
    case (idx)
      0:       return {a0, b0, busy0, done0, pass0, fvalid0, fvec0, err0};
      1:       return {a1, b1, busy1, done1, pass1, fvalid1, fvec1, err1};
      default: return {a2, b2, busy2, done2, pass2, fvalid2, fvec2, 2'b00, err2};
    endcase
  endfunction

  task automatic setStart(input int idx, input logic v);
    case (idx)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic setTt(input int idx, input logic [3:0] tt);
    case (idx)
      0:       tt0 = tt;
      1:       tt1 = tt;
      default: tt2 = tt;
    endcase
  endtask

  function automatic bit isMismatch(input logic [3:0] tt, input int v);
    bit aa, bb, nandOut;
    aa = ((v >> 1) & 1) == 1;
    bb = (v & 1) == 1;
    nandOut = !(aa && bb);
    return tt[v] != nandOut;
  endfunction

  // Runs one full check sequence and compares every cycle against the model.
  // Cycle n means "just after edge E0+n"; abortAt >= 0 pulls reset mid-run.
  task automatic runCheck(input int idx, input int h, input int errMax,
                          input logic [3:0] tt, input string name,
                          input bit holdStart, input int abortAt);
    logic [7:0] expFlags;
    logic [3:0] expErr;
    logic [11:0] obs;
    int errs, firstVec, v;
    bit running;
    logic [1:0] vv;
    logic [1:0] fv;

    setTt(idx, tt);
    @(negedge clk);
    setStart(idx, 1'b1);
    @(negedge clk);
    if (!holdStart) setStart(idx, 1'b0);

    for (int n = 0; n <= 4 * h; n++) begin
      if (n == abortAt) begin
        #2 rst_n = 1'b0;
        #1;
        checks++;
        obs = getObs(idx);
        if (obs !== 12'h000)
          $display("[TB] FAIL %s abort: outputs=%h required=000", name, obs);
        else
          passes++;
        setStart(idx, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (holdStart && n == 4 * h - 1) setStart(idx, 1'b0);

      running = n < 4 * h;
      v = running ? n / h : 0;
      vv = v[1:0];
      errs = 0;
      firstVec = -1;
      for (int k = 0; k < 4; k++) begin
        if ((k + 1) * h <= n && isMismatch(tt, k)) begin
          errs++;
          if (firstVec < 0) firstVec = k;
        end
      end
      if (errs > errMax) errs = errMax;
      expErr = errs[3:0];
      fv = (firstVec < 0) ? 2'b00 : firstVec[1:0];
      expFlags = {vv[1], vv[0], running, !running, (!running && errs == 0),
                  (firstVec >= 0), fv};

      obs = getObs(idx);
      checks++;
      if (obs[11:4] !== expFlags)
        $display("[TB] FAIL %s cycle %0d flags {a,b,busy,done,pass,fv,fvec}: got %b required %b",
                 name, n, obs[11:4], expFlags);
      else
        passes++;
      checks++;
      if (obs[3:0] !== expErr)
        $display("[TB] FAIL %s cycle %0d err_count: got %0d required %0d",
                 name, n, obs[3:0], expErr);
      else
        passes++;
      if (n < 4 * h) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    tt0 = TT_NAND; tt1 = TT_NAND; tt2 = TT_NAND;
    #1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (getObs(i) !== 12'h000)
        $display("[TB] FAIL reset inst%0d: outputs=%h required=000", i, getObs(i));
      else
        passes++;
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_correct_gate;
    runCheck(0, 10, 15, TT_NAND, "correct_h10", 1'b0, -1);
  endtask

  task automatic test_and_gate;
    runCheck(0, 10, 15, TT_AND, "and_gate", 1'b0, -1);
  endtask

  task automatic test_stuck_one;
    runCheck(0, 10, 15, TT_STUCK, "stuck_one", 1'b0, -1);
  endtask

  task automatic test_hold_one;
    runCheck(1, 1, 15, TT_NAND, "hold1_start_held", 1'b1, -1);
  endtask

  task automatic test_back_to_back;
    runCheck(1, 1, 15, TT_AND, "b2b_first", 1'b0, -1);
    runCheck(1, 1, 15, TT_NAND, "b2b_rerun", 1'b0, -1);
  endtask

  task automatic test_reset_mid_run;
    runCheck(0, 10, 15, TT_AND, "abort_run", 1'b0, 23);
    runCheck(0, 10, 15, TT_NAND, "after_abort", 1'b0, -1);
  endtask

  task automatic test_saturation;
    runCheck(2, 3, 3, TT_AND, "saturate", 1'b0, -1);
  endtask

  task automatic test_random_gates;
    logic [3:0] tt;
    for (int i = 0; i < 6; i++) begin
      tt = 4'($urandom);
      runCheck(1, 1, 15, tt, "random_h1", 1'b0, -1);
      tt = 4'($urandom);
      runCheck(2, 3, 3, tt, "random_h3", 1'b0, -1);
    end
    tt = 4'($urandom);
    runCheck(0, 10, 15, tt, "random_h10", 1'b0, -1);
  endtask

  initial begin
    test_reset;
    test_correct_gate;
    test_and_gate;
    test_stuck_one;
    test_hold_one;
    test_back_to_back;
    test_reset_mid_run;
    test_saturation;
    test_random_gates;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/nand_vector_checker.md
# nand_vector_checker

Clocked stimulus-and-check stage for a 2-input NAND gate. It drives all four input vectors into the gate under test, holds each vector for a programmable settle time, samples the gate output and compares it with the expected NAND result. It reports an error count, the first failing vector, and a pass/done summary. It sits on both sides of the gate: it feeds its inputs and consumes its output.

## Interface
- HOLD_CYCLES, 10, clock cycles each vector is driven before the gate output is sampled; legal range ≥1.
- ERR_W, 4, width of the error counter.

- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begins a run; sampled in IDLE or DONE only.
- a  output  1  gate input A, registered.
- b  output  1  gate input B, registered.
- y  input  1  gate output under test.
- busy  output  1  high while vectors are being driven.
- done  output  1  high level after a run completes; held until the next start.
- pass  output  1  high with done when err_count == 0.
- err_count  output  ERR_W  number of mismatching vectors; saturates at 2^ERR_W-1.
- fail_valid  output  1  a mismatch has been recorded this run.
- fail_vec  output  2  {a,b} of the first mismatching vector.

## Operation
- States: IDLE, DRIVE, DONE.
- Reset (async, rst_n=0): state=IDLE, and all outputs are 0, including a, b, busy, done, pass, err_count, fail_valid and fail_vec. Deassertion takes effect on the next clk edge.
- Vector index vec (2 bits) steps in order 0,1,2,3. {a,b}=vec, so the sequence is 00, 01, 10, 11.
- Expected output: exp = ~(a & b), giving 1,1,1,0 for vec 0..3.
- IDLE or DONE with start=1, at edge E0:
  - enter DRIVE, vec=0, {a,b}=00;
  - hold counter = HOLD_CYCLES-1;
  - busy=1, done=0, pass=0;
  - err_count=0, fail_valid=0, fail_vec=0.
- DRIVE, counter≠0: counter decrements; a and b hold.
- DRIVE, counter==0 (sample edge): y is compared with exp.
  - Any y value other than exp counts as a mismatch, including X or Z (case-inequality).
  - On mismatch: err_count increments unless saturated. If fail_valid=0, fail_vec={a,b} and fail_valid=1.
  - If vec<3: vec increments, {a,b} update to the new vector, and the counter reloads HOLD_CYCLES-1.
  - If vec==3: enter DONE, {a,b}=00, busy=0, done=1. pass=1 iff the final err_count, including this sample, is 0.
- DONE: all result outputs hold. start restarts the run as from IDLE.
- start is ignored while in DRIVE.
- rst_n low mid-run aborts immediately to reset values. No partial results are retained.

## Timing
- {a,b} changes on the edge after which the vector is applied. Each vector is stable for exactly HOLD_CYCLES cycles before its sample edge.
- Sample edges fall at E0 + k·HOLD_CYCLES for k=1..4.
- done, pass and busy=0 become visible after edge E0 + 4·HOLD_CYCLES. Run length is 4·HOLD_CYCLES cycles.
- HOLD_CYCLES=1: each vector is sampled on the edge after it is applied; the run takes 4 cycles.
- Mismatch on the last vector: err_count, fail_* and done/pass all update on the same edge. pass must reflect that mismatch.
- Error counter saturation: an increment at 2^ERR_W-1 leaves the counter unchanged. This is reachable only with ERR_W≤2.
- The block adds no combinational path from y to any output. All outputs are registered.

## Test plan
- Correct NAND gate, HOLD_CYCLES=10, start pulsed 1 cycle → {a,b} steps 00/01/10/11 every 10 cycles; done=1 and pass=1 exactly 40 cycles after start; err_count=0; fail_valid=0.
- AND gate substituted for the gate → all 4 vectors mismatch; err_count=4, fail_vec=00, fail_valid=1, pass=0.
- Gate output stuck at 1 → only vec 3 mismatches; err_count=1, fail_vec=11; fail_valid and err_count update on the same edge as done=1, with pass=0.
- HOLD_CYCLES=1 with a correct gate → done after 4 cycles, pass=1. Start held high during DRIVE does not restart the run. Start in DONE reruns and clears err_count to 0 on its edge.
- rst_n pulsed low mid-run (during vec 2) → a, b, busy, done, err_count and fail_valid go to 0 immediately, without waiting for clk. After release, a new start completes a full 4·HOLD_CYCLES run.
- ERR_W=2, AND gate substituted → err_count saturates at 3 after the fourth mismatch; pass=0.
